uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter: serialises one parallel word per frame onto txd. Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Bit timing comes from the shared oversampling tick also used by the receiver. Each bit lasts OVERSAMPLE tick periods.
- Sits beside the receiver inside UART_top and drives the echo/transmit path on txd.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, tick rising edges per bit period (>=2).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tick  input  1  oversampling tick, clk-synchronous. May be a 1-cycle pulse or a square wave; only rising edges count.
- tx_data  input  DATA_BITS  word to send; sampled on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- txd  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: txd=1, tx_busy=0, tx_done=0, state=IDLE, tick counter=0, tick_d=0.
- tx_ready is 0 while rst is high.
- Tick edge: tick_rise = tick & ~tick_d, with tick_d registered every clk. A tick held high counts as one edge.
- Handshake:
  - tx_ready = (state==IDLE) & ~rst.
  - Transfer occurs on a clk edge where tx_valid & tx_ready. tx_data is latched into the shift register there.
  - The tick counter clears on transfer.
  - tx_valid without tx_ready has no effect. The source holds it.
  - tx_data changes after acceptance do not affect the current frame.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: txd=1, tx_busy=0. On transfer go to START. txd=0 and tx_busy=1 from the next cycle.
  - Bit end: tick counter increments on tick_rise. A bit ends on the tick_rise where counter==OVERSAMPLE-1; the counter then wraps to 0.
  - START: txd=0. At bit end go to DATA with bit index 0.
  - DATA: txd = shift[0]. At bit end, shift right and increment the bit index. After bit DATA_BITS-1, go to PARITY (if PARITY!=0), else STOP.
  - PARITY: txd = ^data (even) or ~^data (odd). At bit end go to STOP.
  - STOP: txd=1. After STOP_BITS bit ends, go to IDLE and assert tx_done for exactly that one cycle.
- Back-to-back: tx_ready is high in the same cycle as tx_done. A word accepted then starts its start bit on the next cycle, with no extra idle bit.
- Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods. The start bit is measured from acceptance to the OVERSAMPLE-th tick_rise, so its wall-clock length has up to 1 tick-period phase error.
- txd is a registered output, glitch-free.
- Reset mid-frame: frame aborts at the next clk edge. txd=1, no tx_done, tx_ready=1 in the first cycle after rst falls.
- Reset coincident with transfer: reset wins; the word is dropped.
- Illegal parameter values raise an elaboration-time $error.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - default OVERSAMPLE.
- The receiver also uses uart_pkg.
- Sub-module uart_bit_timer holds the tick edge detect and the oversample counter. It has a clear input and a bit_end pulse output, and is reusable by the receiver.

Test Plan:
- Basic 8N1 frame: defaults, send 0xA5.
  -> txd = 0,1,0,1,0,0,1,0,1,1, each level for 16 tick rises.
  -> Exactly one tx_done pulse; tx_busy high throughout the frame.
- Loopback: txd wired to UART_top rxd, send 0xA5 then 0x3C.
  -> data_ready pulses twice; data_out reads A5 then 3C.
- Back-to-back: tx_valid held high with 0x00 then 0xFF.
  -> Second start bit begins the cycle after tx_done.
  -> No gap longer than 1 clk between the stop bit and the next start bit.
- Parity: PARITY=1, send 0x07 -> parity bit 1. PARITY=2, send 0x07 -> parity bit 0. STOP_BITS=2 -> stop high for 32 tick rises.
- Reset mid-frame: rst during data bit 3.
  -> txd=1 next cycle; no tx_done.
  -> tx_ready=1 after release; next word 0x55 transmits correctly.
- Robustness:
  - tick held high for 50 clk -> counter advances by 1 only.
  - tx_data changed mid-frame -> transmitted bits unchanged.
  - tx_valid during busy -> not accepted until IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default oversampling.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [8:0] word, input int unsigned mode);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling bit timer: detects tick rising edges and flags the edge that closes a bit period.
// Shared between the UART transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output logic bit_end_c
);

  localparam int unsigned CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_bit_timer: OVERSAMPLE must be at least 2");
  end

  logic          tick_d;
  logic          tick_rise_c;
  logic [CW-1:0] cnt;

  // A tick held high for many cycles contributes a single edge.
  assign tick_rise_c = tick & ~tick_d;
  assign bit_end_c   = tick_rise_c && (cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d <= 1'b0;
      cnt    <= '0;
    end else begin
      tick_d <= tick;
      if (clear || bit_end_c) begin
        cnt <= '0;
      end else if (tick_rise_c) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per frame (start, data LSB first, optional parity, stop bits).
// Bit timing derives from the shared oversampling tick via uart_bit_timer.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [IW-1:0]        bit_idx, bit_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 txd_nxt, busy_nxt, done_nxt;
  logic                 bit_end_c;
  logic                 transfer_c;
  logic                 timer_clear_c;

  assign tx_ready      = (state == ST_IDLE) & ~rst;
  assign transfer_c    = tx_valid & tx_ready;
  // Holding the counter at zero while idle makes the start bit count from acceptance.
  assign timer_clear_c = (state == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .clear     (timer_clear_c),
    .bit_end_c (bit_end_c)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      par_bit  <= par_bit_nxt;
      txd      <= txd_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    par_bit_nxt  = par_bit;
    case (state)
      ST_IDLE: begin
        if (transfer_c) begin
          state_nxt    = ST_START;
          shift_nxt    = tx_data;
          bit_idx_nxt  = '0;
          stop_idx_nxt = 1'b0;
          par_bit_nxt  = parity_of(9'(tx_data), PARITY);
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            state_nxt    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_nxt = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_nxt    = ST_STOP;
          stop_idx_nxt = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            stop_idx_nxt = stop_idx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so txd is registered.
  always_comb begin
    txd_nxt  = 1'b1;
    busy_nxt = 1'b1;
    done_nxt = (state == ST_STOP) && (state_nxt == ST_IDLE);
    case (state_nxt)
      ST_IDLE:   busy_nxt = 1'b0;
      ST_START:  txd_nxt  = 1'b0;
      ST_DATA:   txd_nxt  = shift_nxt[0];
      ST_PARITY: txd_nxt  = par_bit_nxt;
      ST_STOP:   txd_nxt  = 1'b1;
      default:   txd_nxt  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: 8N1, even parity with two stop bits, odd parity,
// back-to-back frames, mid-frame data change, held tick, and reset handling.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tick = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  bit         tick_hold = 1'b0;
  int         sel = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  logic valid0, valid1, valid2;
  logic ready0, ready1, ready2;
  logic txd0, txd1, txd2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic txd_m, ready_m, busy_m, done_m;

  assign valid0  = tx_valid && (sel == 0);
  assign valid1  = tx_valid && (sel == 1);
  assign valid2  = tx_valid && (sel == 2);
  assign txd_m   = (sel == 0) ? txd0   : (sel == 1) ? txd1   : txd2;
  assign ready_m = (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready2;
  assign busy_m  = (sel == 0) ? busy0  : (sel == 1) ? busy1  : busy2;
  assign done_m  = (sel == 0) ? done0  : (sel == 1) ? done1  : done2;

  uart_tx dut0 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid0),
    .tx_ready(ready0), .txd(txd0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx #(.PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid1),
    .tx_ready(ready1), .txd(txd1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx #(.PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid2),
    .tx_ready(ready2), .txd(txd2), .tx_busy(busy2), .tx_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 4 clocks, or held high while tick_hold is set.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (tick_hold) begin
        tick = 1'b1;
      end else begin
        tick = (div == 3);
        div  = (div + 1) % 4;
      end
    end
  end

  // Reference count of tick rising edges as seen at each clk edge.
  logic tick_prev = 1'b0;
  int   rise_cnt = 0;
  always @(posedge clk) begin
    tick_prev <= tick;
    if (tick && !tick_prev) rise_cnt <= rise_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then records the level of each bit period (16 tick rises each),
  // counting any level change inside a period, busy drops and premature done pulses.
  task automatic capture(input int nbits, input bit drop_valid, input int chg_rel,
                         input logic [7:0] chg_data, input int hold_rel,
                         output logic [15:0] lv, output int glitches, output int busy_lo,
                         output int dones_early, output bit end_ok, output int wait_cyc,
                         output bit to);
    int r0, rel, b, prev_b, hold_left;
    bit changed, held;
    lv = '0; glitches = 0; busy_lo = 0; dones_early = 0; end_ok = 0;
    wait_cyc = 0; to = 0; changed = 0; held = 0; hold_left = 0;
    do begin
      @(posedge clk); #1;
      wait_cyc++;
    end while (txd_m !== 1'b0 && wait_cyc < 4000);
    if (txd_m !== 1'b0) begin
      to = 1;
      return;
    end
    if (drop_valid) tx_valid = 1'b0;
    r0 = rise_cnt;
    prev_b = -1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      rel = rise_cnt - r0;
      if (rel >= nbits * 16) begin
        end_ok = (done_m === 1'b1) && (txd_m === 1'b1) && (ready_m === 1'b1);
        return;
      end
      b = rel / 16;
      if (b != prev_b) begin
        lv[b] = txd_m;
        prev_b = b;
      end else if (txd_m !== lv[b]) begin
        glitches++;
      end
      if (busy_m !== 1'b1) busy_lo++;
      if (done_m !== 1'b0) dones_early++;
      if (rel == chg_rel && !changed) begin
        tx_data = chg_data;
        changed = 1;
      end
      if (rel == hold_rel && !held) begin
        tick_hold = 1'b1;
        held = 1;
        hold_left = 50;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) tick_hold = 1'b0;
      end
      @(posedge clk); #1;
    end
    to = 1;
  endtask

  task automatic send(input int s, input logic [7:0] d, input int nbits,
                      input logic [15:0] exp, input int hold_rel, input string tag);
    logic [15:0] lv;
    int gl, bl, de, wc;
    bit eok, to;
    @(negedge clk);
    sel = s;
    tx_data = d;
    tx_valid = 1'b1;
    capture(nbits, 1'b1, -1, 8'h00, hold_rel, lv, gl, bl, de, eok, wc, to);
    chk({tag, " timeout"}, 32'(to), 32'd0);
    chk({tag, " bits"}, 32'(lv), 32'(exp));
    chk({tag, " glitches"}, gl, 0);
    chk({tag, " busy_low"}, bl, 0);
    chk({tag, " early_done"}, de, 0);
    chk({tag, " end_done_idle"}, 32'(eok), 32'd1);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    logic [15:0] lv;
    int gl, bl, de, wc, r0;
    bit eok, to;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset txd", 32'(txd_m), 32'd1);
    chk("reset busy", 32'(busy_m), 32'd0);
    chk("reset done", 32'(done_m), 32'd0);
    chk("reset ready", 32'(ready_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready after reset", 32'(ready_m), 32'd1);

    // 8N1 frames.
    send(0, 8'hA5, 10, 16'h034A, -1, "8n1_a5");
    send(0, 8'h3C, 10, 16'h0278, -1, "8n1_3c");

    // Back-to-back with valid held, tx_data changed mid-frame.
    @(negedge clk);
    sel = 0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    capture(10, 1'b0, 40, 8'hFF, -1, lv, gl, bl, de, eok, wc, to);
    chk("b2b first timeout", 32'(to), 32'd0);
    chk("b2b first bits", 32'(lv), 32'h0200);
    chk("b2b first glitches", gl, 0);
    chk("b2b first end", 32'(eok), 32'd1);
    capture(10, 1'b1, -1, 8'h00, -1, lv, gl, bl, de, eok, wc, to);
    chk("b2b gap cycles", wc, 1);
    chk("b2b second bits", 32'(lv), 32'h03FE);
    chk("b2b second glitches", gl, 0);
    chk("b2b second early_done", de, 0);
    chk("b2b second end", 32'(eok), 32'd1);
    @(posedge clk); #1;
    chk("b2b done one cycle", 32'(done_m), 32'd0);

    // Parity variants.
    send(1, 8'h07, 12, 16'h0E0E, -1, "even2_07");
    send(1, 8'h03, 12, 16'h0C06, -1, "even2_03");
    send(2, 8'h07, 11, 16'h040E, -1, "odd_07");
    send(2, 8'h00, 11, 16'h0600, -1, "odd_00");

    // Tick held high for 50 clocks inside data bit 1.
    send(0, 8'h96, 10, 16'h032C, 40, "tick_hold_96");

    // Reset during data bit 3 (a 0 bit of 0xA5).
    @(negedge clk);
    sel = 0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    wc = 0;
    do begin
      @(posedge clk); #1;
      wc++;
    end while (txd_m !== 1'b0 && wc < 4000);
    chk("rst_mid start seen", 32'(txd_m), 32'd0);
    tx_valid = 1'b0;
    r0 = rise_cnt;
    wc = 0;
    while (rise_cnt - r0 < 72 && wc < 4000) begin
      @(posedge clk); #1;
      wc++;
    end
    chk("rst_mid data bit3 level", 32'(txd_m), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid txd", 32'(txd_m), 32'd1);
    chk("rst_mid busy", 32'(busy_m), 32'd0);
    chk("rst_mid ready", 32'(ready_m), 32'd0);
    chk("rst_mid done", 32'(done_m), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid ready after", 32'(ready_m), 32'd1);
    chk("rst_mid txd after", 32'(txd_m), 32'd1);
    chk("rst_mid done after", 32'(done_m), 32'd0);
    send(0, 8'h55, 10, 16'h02AA, -1, "after_rst_55");

    // Reset coincident with a transfer drops the word.
    @(negedge clk);
    rst = 1'b1;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xfer txd", 32'(txd_m), 32'd1);
    chk("rst_xfer busy", 32'(busy_m), 32'd0);
    chk("rst_xfer ready", 32'(ready_m), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
